// File: rtl/imem_program_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_program_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader for the 32-word instruction memory; holds the core halted until verified.
// Define OPCODE_CHECK_EN to reject words whose opcode exceeds 8'h0B.
module imem_program_loader #(
   parameter int         DEPTH          = 32,
   parameter int         ADDR_W         = 5,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   imem_program_loader_if.slave rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code
);

   localparam int         CNT_W   = $clog2(DEPTH + 1);
   localparam int         TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      CHECK,
      DONE,
      ERR
   } state_t;

   state_t           state;
   logic [23:0]      word;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] word_idx;
   logic [CNT_W-1:0] n_words;
   logic [7:0]       csum;
   logic [TMO_W-1:0] tmo;

   logic xfer;
   logic busy;
   logic tmo_hit;
   logic bad_op;

   // Single-port memory: no byte may land in the write cycle.
   assign rx.rx_ready = ~rst & ~imem_we;
   assign xfer        = rx.rx_valid & rx.rx_ready;
   assign busy        = (state == COUNT) | (state == DATA) | (state == CHECK);
   assign tmo_hit     = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

`ifdef OPCODE_CHECK_EN
   assign bad_op = (word[23:16] > 8'h0B);
`else
   assign bad_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word       <= '0;
         byte_cnt   <= '0;
         word_idx   <= '0;
         n_words    <= '0;
         csum       <= '0;
         tmo        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_run    <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 3'd0;
      end else begin
         imem_we <= 1'b0;
         unique case (state)
            IDLE, DONE, ERR: begin
               if (xfer && rx.rx_data == SYNC_BYTE) begin
                  state    <= COUNT;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  err_code <= 3'd0;
                  cpu_run  <= 1'b0;
                  csum     <= '0;
                  word_idx <= '0;
                  byte_cnt <= '0;
                  tmo      <= '0;
               end
            end
            COUNT: begin
               if (xfer) begin
                  if (rx.rx_data == 8'd0 || rx.rx_data > DEPTH_B) begin
                     state    <= ERR;
                     error    <= 1'b1;
                     err_code <= 3'd1;
                  end else begin
                     n_words <= rx.rx_data[CNT_W-1:0];
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  csum     <= csum ^ rx.rx_data;
                  word     <= {word[15:0], rx.rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (bad_op) begin
                        state    <= ERR;
                        error    <= 1'b1;
                        err_code <= 3'd4;
                     end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_W-1:0];
                        imem_wdata <= {word, rx.rx_data};
                        word_idx   <= word_idx + CNT_W'(1);
                        if (word_idx == n_words - CNT_W'(1))
                           state <= CHECK;
                     end
                  end
               end
            end
            CHECK: begin
               if (xfer) begin
                  if (rx.rx_data == csum) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     cpu_run <= 1'b1;
                  end else begin
                     state    <= ERR;
                     error    <= 1'b1;
                     err_code <= 3'd2;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Inter-byte watchdog, only while a frame is in flight.
         if (busy) begin
            if (xfer) begin
               tmo <= '0;
            end else if (tmo_hit) begin
               state    <= ERR;
               error    <= 1'b1;
               err_code <= 3'd3;
            end else begin
               tmo <= tmo + TMO_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized scoreboard bench for imem_program_loader; a frame-level model predicts writes and status.
module tb_imem_program_loader;

   localparam int DEPTH = 32;
`ifdef OPCODE_CHECK_EN
   localparam bit OPC = 1'b1;
`else
   localparam bit OPC = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   typedef struct packed {
      logic       d;
      logic       e;
      logic [2:0] c;
      logic       r;
   } st_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_run;
   logic        done;
   logic        error;
   logic [2:0]  err_code;

   imem_program_loader_if bus ();

   imem_program_loader dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (bus),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int  n_chk  = 0;
   int  n_fail = 0;
   wr_t wq[$];
   st_t sq[$];

   localparam st_t S_DONE = '{d: 1'b1, e: 1'b0, c: 3'd0, r: 1'b1};

   function automatic st_t s_err(input logic [2:0] c);
      return '{d: 1'b0, e: 1'b1, c: c, r: 1'b0};
   endfunction

   function automatic void check(input string nm, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: pops expectations whenever the DUT writes or reports a result.
   initial begin
      logic prev;
      wr_t  w;
      st_t  s;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            check("rdy_vs_we", bus.rx_ready, !imem_we);
            if (imem_we) begin
               if (wq.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  w = wq.pop_front();
                  check("wr_addr", imem_addr, w.a);
                  check("wr_data", imem_wdata, w.d);
               end
            end
            if ((done | error) && !prev) begin
               if (sq.size() == 0) begin
                  check("unexpected_status", 1, 0);
               end else begin
                  s = sq.pop_front();
                  check("status", {done, error, err_code, cpu_run}, s);
               end
            end
            prev = done | error;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      int g;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      g = 0;
      while (!bus.rx_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) check("rx_ready_stuck", 0, 1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   // Frame-level reference: parse the frame, predict writes/status, send what the DUT would consume.
   task automatic model_send(input logic [7:0] f[$], input int gapmax);
      logic [7:0]  tx[$];
      logic [7:0]  x;
      logic [31:0] w;
      int          n;
      bit          stop;
      n = int'(f[1]);
      tx.push_back(f[0]);
      tx.push_back(f[1]);
      if (n == 0 || n > DEPTH) begin
         sq.push_back(s_err(3'd1));
      end else begin
         x    = 8'h00;
         stop = 1'b0;
         for (int i = 0; i < n && !stop; i++) begin
            w = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
            for (int k = 0; k < 4; k++) begin
               tx.push_back(f[2+4*i+k]);
               x = x ^ f[2+4*i+k];
            end
            if (OPC && f[2+4*i] > 8'h0B) begin
               sq.push_back(s_err(3'd4));
               stop = 1'b1;
            end else begin
               wq.push_back({5'(i), w});
            end
         end
         if (!stop) begin
            tx.push_back(f[2+4*n]);
            sq.push_back(f[2+4*n] == x ? S_DONE : s_err(3'd2));
         end
      end
      for (int i = 0; i < tx.size(); i++) begin
         send(tx[i]);
         if (i == 0) check("sync_clears_run", {cpu_run, done}, 2'b00);
         if (gapmax > 0)
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
      end
   endtask

   task automatic rand_frame();
      logic [7:0] f[$];
      logic [7:0] x;
      logic [7:0] g;
      int kind;
      int n;
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) begin
         g = 8'($urandom_range(0, 255));
         if (g == 8'hA5) g = 8'h00;
         send(g);
      end
      f.push_back(8'hA5);
      if (kind == 0) begin
         n = $urandom_range(0, 1) ? 0 : $urandom_range(33, 255);
         f.push_back(8'(n));
      end else begin
         n = $urandom_range(1, DEPTH);
         f.push_back(8'(n));
         x = 8'h00;
         for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
               if (k == 0)
                  g = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(12, 255))
                                                   : 8'($urandom_range(0, 11));
               else
                  g = 8'($urandom_range(0, 255));
               f.push_back(g);
               x = x ^ g;
            end
         end
         if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
         f.push_back(x);
      end
      model_send(f, $urandom_range(0, 1) ? 0 : 3);
   endtask

   initial begin
      logic [7:0] fr[$];
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.rx_ready, 0);
      check("rst_outs", {imem_we, cpu_run, done, error, err_code}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", bus.rx_ready, 1);

      fr = '{8'hA5, 8'h02, 8'h02, 8'h0A, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
      model_send(fr, 0);
      repeat (2) @(negedge clk);
      check("done_level", {done, cpu_run, err_code}, 5'b11000);
      fr = '{8'hA5, 8'h02, 8'h02, 8'h0A, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09};
      model_send(fr, 2);
      fr = '{8'hA5, 8'h21};
      model_send(fr, 0);
      fr = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      model_send(fr, 0);
      fr = '{8'hA5, 8'h01, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0C};
      model_send(fr, 0);

      // Timeout lands exactly on the 1024th idle cycle; the next sync clears it.
      sq.push_back(s_err(3'd3));
      send(8'hA5);
      send(8'h01);
      send(8'h0A);
      send(8'h00);
      repeat (1023) @(negedge clk);
      check("tmo_not_early", {error, err_code}, 4'b0000);
      @(negedge clk);
      check("tmo_at_1024", {error, err_code}, 4'b1011);
      send(8'hA5);
      check("sync_clears_err", {error, err_code}, 4'b0000);
      sq.push_back(s_err(3'd1));
      send(8'h00);

      // Reset in the middle of a frame aborts it cleanly.
      send(8'hA5);
      send(8'h02);
      send(8'h01);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", bus.rx_ready, 0);
      check("midrst_outs", {imem_we, cpu_run, done, error, err_code}, 0);
      rst = 1'b0;
      @(negedge clk);

      repeat (40) rand_frame();

      repeat (10) @(negedge clk);
      check("wq_drained", wq.size(), 0);
      check("sq_drained", sq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
